// File: rtl/piece_move_resolver.sv
// piece_move_resolver: builds the candidate placement for one move request,
// scans it against the board one row per cycle through a synchronous read
// port (plus wall/floor checks), and returns one registered verdict.
module piece_move_resolver #(
  parameter int BOARD_WIDTH  = 10,
  parameter int BOARD_HEIGHT = 20,
  parameter int PIECE_N      = 4,
  parameter int XW           = $clog2(BOARD_WIDTH) + 1,
  parameter int YW           = $clog2(BOARD_HEIGHT) + 1
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  req_valid,
  output logic                                  req_ready,
  input  logic [2:0]                            req_move,
  input  logic                                  no_piece,
  input  logic signed [XW-1:0]                  piece_x,
  input  logic signed [YW-1:0]                  piece_y,
  input  logic [PIECE_N-1:0][PIECE_N-1:0]       piece_grid,
  output logic                                  board_rd_en,
  output logic [$clog2(BOARD_HEIGHT)-1:0]       board_rd_row,
  input  logic [BOARD_WIDTH-1:0]                board_rd_data,
  output logic                                  rsp_valid,
  output logic                                  rsp_collision,
  output logic                                  rsp_oob,
  output logic signed [XW-1:0]                  rsp_x,
  output logic signed [YW-1:0]                  rsp_y,
  output logic [PIECE_N-1:0][PIECE_N-1:0]       rsp_grid
);
  // One extra bit over the widest coordinate so +/-1 and +row never wrap.
  localparam int AW  = ((XW > YW) ? XW : YW) + 1;
  localparam int RW  = $clog2(BOARD_HEIGHT);
  localparam int RCW = (PIECE_N > 1) ? $clog2(PIECE_N) : 1;
  localparam logic signed [AW-1:0] W_S = AW'(BOARD_WIDTH);
  localparam logic signed [AW-1:0] H_S = AW'(BOARD_HEIGHT);
  localparam logic signed [AW-1:0] N_S = AW'(PIECE_N);

  typedef logic [PIECE_N-1:0][PIECE_N-1:0] grid_t;
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, RESP} state_t;

  state_t                 state;
  grid_t                  cand;
  logic signed [AW-1:0]   cx, cy;
  logic                   np, coll, oob;
  logic [RCW-1:0]         r;
  logic                   pend;
  logic [BOARD_WIDTH-1:0] pend_mask;

  grid_t                  nxt_grid;
  logic signed [AW-1:0]   nxt_x, nxt_y;
  logic [PIECE_N-1:0]     row_bits, wall;
  logic [BOARD_WIDTH-1:0] row_mask;
  logic signed [AW-1:0]   abs_r;
  logic                   occ, row_hi, rd, hit;

  // Candidate position/grid from the live request; only sampled on acceptance.
  always_comb begin
    nxt_x    = {{(AW-XW){piece_x[XW-1]}}, piece_x};
    nxt_y    = {{(AW-YW){piece_y[YW-1]}}, piece_y};
    nxt_grid = piece_grid;
    case (req_move)
      3'd1: nxt_x = nxt_x - AW'(1);
      3'd2: nxt_x = nxt_x + AW'(1);
      3'd3: nxt_y = nxt_y + AW'(1);
      3'd4: for (int a = 0; a < PIECE_N; a++)
              for (int b = 0; b < PIECE_N; b++)
                nxt_grid[a][b] = piece_grid[b][PIECE_N-1-a];
      3'd5: for (int a = 0; a < PIECE_N; a++)
              for (int b = 0; b < PIECE_N; b++)
                nxt_grid[a][b] = piece_grid[PIECE_N-1-b][a];
      default: ;
    endcase
  end

  // Per grid column: occupancy of the scanned row and wall violation.
  // Walls are checked for every occupied cell, including rows above the board.
  for (genvar gc = 0; gc < PIECE_N; gc++) begin : g_cell
    logic signed [AW-1:0] col;
    assign row_bits[gc] = cand[gc][r];
    assign col          = cx + AW'(gc);
    assign wall[gc]     = row_bits[gc] & (col[AW-1] | (col >= W_S));
  end

  // Per board column: candidate row mask shifted by cx, in-range columns only.
  for (genvar gb = 0; gb < BOARD_WIDTH; gb++) begin : g_col
    logic signed [AW-1:0] off;
    assign off          = AW'(gb) - cx;
    assign row_mask[gb] = ~off[AW-1] & (off < N_S) & row_bits[off[RCW-1:0]];
  end

  assign abs_r        = cy + $signed(AW'(r));
  assign occ          = |row_bits;
  assign row_hi       = abs_r >= H_S;
  assign rd           = (state == SCAN) & occ & ~abs_r[AW-1] & ~row_hi;
  assign hit          = pend & |(pend_mask & board_rd_data);
  assign board_rd_en  = rd;
  assign board_rd_row = rd ? abs_r[RW-1:0] : '0;
  assign req_ready    = (state == IDLE);

  // Request FSM: accept, scan rows, drain the last compare, publish verdict.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      cand          <= '0;
      cx            <= '0;
      cy            <= '0;
      np            <= 1'b0;
      coll          <= 1'b0;
      oob           <= 1'b0;
      r             <= '0;
      pend          <= 1'b0;
      pend_mask     <= '0;
      rsp_valid     <= 1'b0;
      rsp_collision <= 1'b0;
      rsp_oob       <= 1'b0;
      rsp_x         <= '0;
      rsp_y         <= '0;
      rsp_grid      <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          cand  <= nxt_grid;
          cx    <= nxt_x;
          cy    <= nxt_y;
          np    <= no_piece;
          coll  <= 1'b0;
          oob   <= 1'b0;
          r     <= '0;
          pend  <= 1'b0;
          state <= SCAN;
        end
        SCAN: begin
          coll      <= coll | hit | (occ & row_hi) | (|wall);
          oob       <= oob | (occ & row_hi) | (|wall);
          pend      <= rd;
          pend_mask <= row_mask;
          r         <= r + 1'b1;
          if (r == RCW'(PIECE_N-1)) state <= DRAIN;
        end
        DRAIN: begin
          coll          <= coll | hit;
          pend          <= 1'b0;
          rsp_valid     <= 1'b1;
          rsp_collision <= ~np & (coll | hit);
          rsp_oob       <= ~np & oob;
          rsp_x         <= cx[XW-1:0];
          rsp_y         <= cy[YW-1:0];
          rsp_grid      <= cand;
          state         <= RESP;
        end
        default: begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_piece_move_resolver.sv
// Bench for piece_move_resolver: hand vectors, rotation back-to-back,
// reset mid-scan, then random requests against a cell-level reference model.
module tb_piece_move_resolver;
  localparam int BW = 10;
  localparam int BH = 20;
  localparam int N  = 4;
  localparam int XW = $clog2(BW) + 1;
  localparam int YW = $clog2(BH) + 1;

  typedef logic [N-1:0][N-1:0] grid_t;

  logic                   clk = 1'b0;
  logic                   reset_n = 1'b0;
  logic                   req_valid = 1'b0;
  logic                   req_ready;
  logic [2:0]             req_move = '0;
  logic                   no_piece = 1'b0;
  logic signed [XW-1:0]   piece_x = '0;
  logic signed [YW-1:0]   piece_y = '0;
  grid_t                  piece_grid = '0;
  logic                   board_rd_en;
  logic [$clog2(BH)-1:0]  board_rd_row;
  logic [BW-1:0]          board_rd_data;
  logic                   rsp_valid, rsp_collision, rsp_oob;
  logic signed [XW-1:0]   rsp_x;
  logic signed [YW-1:0]   rsp_y;
  grid_t                  rsp_grid;

  int checks = 0;
  int errors = 0;

  logic [BW-1:0] board [BH];
  logic [31:0]   rd_mask;
  int            rd_cnt;

  piece_move_resolver #(.BOARD_WIDTH(BW), .BOARD_HEIGHT(BH), .PIECE_N(N)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_move(req_move), .no_piece(no_piece), .piece_x(piece_x), .piece_y(piece_y),
    .piece_grid(piece_grid), .board_rd_en(board_rd_en), .board_rd_row(board_rd_row),
    .board_rd_data(board_rd_data), .rsp_valid(rsp_valid), .rsp_collision(rsp_collision),
    .rsp_oob(rsp_oob), .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_grid(rsp_grid));

  always #5 clk = ~clk;

  // Board RAM: one-cycle read latency, garbage when not enabled.
  always @(posedge clk) begin
    if (board_rd_en && board_rd_row < BH) board_rd_data <= board[board_rd_row];
    else board_rd_data <= BW'($urandom);
  end

  // Log every read strobe.
  always @(negedge clk) begin
    if (board_rd_en) begin
      rd_mask[board_rd_row] = 1'b1;
      rd_cnt++;
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: move each occupied cell to its absolute spot and test it.
  function automatic void model(input logic [2:0] mv, input bit np, input int x, input int y,
                                input grid_t g, output grid_t cg, output int cx, output int cy,
                                output bit coll, output bit oob, output logic [31:0] rmask);
    int ax, ay, col, row;
    cx = x; cy = y; cg = '0; coll = 0; oob = 0; rmask = '0;
    if (mv == 1) cx = x - 1;
    else if (mv == 2) cx = x + 1;
    else if (mv == 3) cy = y + 1;
    for (int sx = 0; sx < N; sx++)
      for (int sy = 0; sy < N; sy++)
        if (g[sx][sy]) begin
          ax = sx; ay = sy;
          if (mv == 4) begin ax = N-1-sy; ay = sx; end
          else if (mv == 5) begin ax = sy; ay = N-1-sx; end
          cg[ax][ay] = 1'b1;
          col = cx + ax; row = cy + ay;
          if (col < 0 || col >= BW || row >= BH) begin coll = 1; oob = 1; end
          else if (row >= 0 && board[row][col]) coll = 1;
          if (row >= 0 && row < BH) rmask[row] = 1'b1;
        end
    if (np) begin coll = 0; oob = 0; end
  endfunction

  task automatic clear_board();
    for (int i = 0; i < BH; i++) board[i] = '0;
  endtask

  // Issue one request, scramble inputs after acceptance, collect the verdict.
  task automatic do_req(input logic [2:0] mv, input bit np, input int x, input int y,
                        input grid_t g, output grid_t rg, output int rx, output int ry,
                        output bit rc, output bit ro, output logic [31:0] rm);
    int n, lat;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    req_valid = 1; req_move = mv; no_piece = np;
    piece_x = XW'(x); piece_y = YW'(y); piece_grid = g;
    rd_mask = '0; rd_cnt = 0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0; req_move = 3'($urandom); no_piece = 1'($urandom);
    piece_x = XW'($urandom); piece_y = YW'($urandom); piece_grid = grid_t'($urandom);
    lat = 1;
    while (!rsp_valid && lat < 20) begin @(negedge clk); lat++; end
    chk("latency", lat, N + 2);
    rg = rsp_grid; rx = int'(rsp_x); ry = int'(rsp_y);
    rc = rsp_collision; ro = rsp_oob; rm = rd_mask;
    @(negedge clk);
    chk("rsp one-cycle", rsp_valid, 0);
    chk("ready after rsp", req_ready, 1);
  endtask

  typedef struct {
    logic [2:0]  mv;
    bit          np;
    int          x, y;
    grid_t       g;
    bit          row10;
    bit          ec, eo;
    int          ex, ey;
    logic [31:0] erd;
  } vec_t;

  initial begin
    vec_t        vt [6];
    grid_t       o_pc, i_pc, dot, t_pc, t_cw, t_ccw, rg, mg;
    int          rx, ry, mx, my, k, seen;
    bit          rc, ro, mc, mo;
    logic [31:0] rm, mrm;
    logic [2:0]  mv;
    bit          np;
    int          x, y;
    grid_t       g;

    o_pc = '0; o_pc[1][1] = 1; o_pc[1][2] = 1; o_pc[2][1] = 1; o_pc[2][2] = 1;
    i_pc = '0; for (int j = 0; j < N; j++) i_pc[0][j] = 1;
    dot  = '0; dot[1][2] = 1;
    t_pc = '0;  t_pc[0][1] = 1;  t_pc[1][1] = 1;  t_pc[2][1] = 1;  t_pc[1][0] = 1;
    t_cw = '0;  t_cw[2][0] = 1;  t_cw[2][1] = 1;  t_cw[2][2] = 1;  t_cw[3][1] = 1;
    t_ccw = '0; t_ccw[1][1] = 1; t_ccw[1][2] = 1; t_ccw[1][3] = 1; t_ccw[0][2] = 1;

    //          mv    np  x  y  grid  r10 ec eo ex  ey  reads
    vt[0] = '{3'd3, 0, 4, 0,  o_pc, 0, 0, 0, 4,  1,  32'h0000_000C};
    vt[1] = '{3'd3, 0, 4, 17, o_pc, 0, 1, 1, 4,  18, 32'h0008_0000};
    vt[2] = '{3'd1, 0, 0, 5,  i_pc, 0, 1, 1, -1, 5,  32'h0000_01E0};
    vt[3] = '{3'd1, 1, 0, 5,  i_pc, 0, 0, 0, -1, 5,  32'h0000_01E0};
    vt[4] = '{3'd0, 0, 4, 8,  dot,  1, 1, 0, 4,  8,  32'h0000_0400};
    vt[5] = '{3'd1, 0, 4, 8,  dot,  1, 0, 0, 3,  8,  32'h0000_0400};

    clear_board();
    #1;
    chk("reset ready", req_ready, 1);
    chk("reset rsp_valid", rsp_valid, 0);
    chk("reset rd_en", board_rd_en, 0);
    chk("reset rsp_grid", rsp_grid, 0);
    repeat (3) @(negedge clk);
    reset_n = 1;

    // Hand-computed vectors
    for (int i = 0; i < 6; i++) begin
      clear_board();
      if (vt[i].row10) board[10] = 10'b0000100000;
      do_req(vt[i].mv, vt[i].np, vt[i].x, vt[i].y, vt[i].g, rg, rx, ry, rc, ro, rm);
      chk($sformatf("vec%0d collision", i), rc, vt[i].ec);
      chk($sformatf("vec%0d oob", i), ro, vt[i].eo);
      chk($sformatf("vec%0d rsp_x", i), rx, vt[i].ex);
      chk($sformatf("vec%0d rsp_y", i), ry, vt[i].ey);
      chk($sformatf("vec%0d grid", i), rg, vt[i].g);
      chk($sformatf("vec%0d read rows", i), rm, vt[i].erd);
      chk($sformatf("vec%0d read count", i), rd_cnt, $countones(vt[i].erd));
    end

    // Back-to-back rotations with req_valid held high
    clear_board();
    @(negedge clk);
    req_valid = 1; req_move = 3'd4; no_piece = 0; piece_x = 3; piece_y = 5; piece_grid = t_pc;
    @(posedge clk);
    @(negedge clk);
    req_move = 3'd5;
    k = 1; seen = 0;
    while (!req_ready && k < 20) begin
      if (rsp_valid) begin
        seen++;
        chk("cw rsp cycle", k, N + 2);
        chk("cw grid", rsp_grid, t_cw);
        chk("cw collision", rsp_collision, 0);
      end
      @(negedge clk); k++;
    end
    chk("cw rsp seen", seen, 1);
    chk("second accept cycle", k, N + 3);
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    k = 1;
    while (!rsp_valid && k < 20) begin @(negedge clk); k++; end
    chk("ccw latency", k, N + 2);
    chk("ccw grid", rsp_grid, t_ccw);
    chk("ccw rsp_x", int'(rsp_x), 3);
    chk("ccw rsp_y", int'(rsp_y), 5);

    // Reset mid-scan
    @(negedge clk);
    req_valid = 1; req_move = 3'd3; piece_x = 4; piece_y = 0; piece_grid = o_pc;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    @(posedge clk);
    @(posedge clk);
    #2 reset_n = 0;
    #1;
    chk("mid reset ready", req_ready, 1);
    chk("mid reset rsp_valid", rsp_valid, 0);
    chk("mid reset rd_en", board_rd_en, 0);
    chk("mid reset rd_row", board_rd_row, 0);
    chk("mid reset collision", rsp_collision, 0);
    chk("mid reset oob", rsp_oob, 0);
    chk("mid reset rsp_x", rsp_x, 0);
    chk("mid reset rsp_y", rsp_y, 0);
    chk("mid reset rsp_grid", rsp_grid, 0);
    repeat (2) @(negedge clk);
    reset_n = 1;
    seen = 0;
    repeat (10) begin @(negedge clk); if (rsp_valid) seen++; end
    chk("dropped request", seen, 0);
    do_req(3'd3, 0, 4, 0, o_pc, rg, rx, ry, rc, ro, rm);
    chk("post reset collision", rc, 0);
    chk("post reset rsp_y", ry, 1);
    chk("post reset reads", rm, 32'h0000_000C);

    // Random requests against the reference model
    for (int n = 0; n < 200; n++) begin
      for (int i = 0; i < BH; i++) board[i] = BW'($urandom & $urandom & $urandom);
      mv = 3'($urandom);
      np = ($urandom_range(0, 7) == 0);
      x  = $urandom_range(0, 13) - 2;
      y  = $urandom_range(0, 22) - 3;
      g  = grid_t'($urandom & $urandom);
      model(mv, np, x, y, g, mg, mx, my, mc, mo, mrm);
      do_req(mv, np, x, y, g, rg, rx, ry, rc, ro, rm);
      chk($sformatf("rnd%0d collision", n), rc, mc);
      chk($sformatf("rnd%0d oob", n), ro, mo);
      chk($sformatf("rnd%0d rsp_x", n), rx, mx);
      chk($sformatf("rnd%0d rsp_y", n), ry, my);
      chk($sformatf("rnd%0d grid", n), rg, mg);
      chk($sformatf("rnd%0d read rows", n), rm, mrm);
      chk($sformatf("rnd%0d read count", n), rd_cnt, $countones(mrm));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
